// File: rtl/pkt_tx.sv
// -----------------------------------------------------------------------------
// pkt_tx -- packet transmitter over a UART line (8N1, LSB first, idle high).
//
// On a start request the block fetches PKT_LEN payload bytes one at a time
// from an external source by index and sends each as a UART frame. The
// frames follow each other with a single fetch cycle between them. tx comes
// from a flop, so the line follows the state machine one cycle later.
//
// Optional feature: define PKT_TX_CHECKSUM_EN to append one extra frame after
// the payload. That frame carries the XOR of all payload bytes.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (default 434 = 50 MHz / 115200)
//   PKT_LEN      : payload bytes per packet, 1..127
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   packet request, sampled only while idle
//   idx        out  [6:0] index of the payload byte being fetched
//   read_data  in   [7:0] payload byte addressed by idx (combinational source)
//   tx         out  UART line
//   busy       out  high whenever the block is not idle
//   byte_sent  out  one-cycle pulse on the last cycle of each stop bit
//   done       out  one-cycle pulse on the last cycle of the packet
// -----------------------------------------------------------------------------
module pkt_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PKT_LEN      = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [6:0] idx,
   input  logic [7:0] read_data,
   output logic       tx,
   output logic       busy,
   output logic       byte_sent,
   output logic       done
);

   // One bit is the minimum width, so CLKS_PER_BIT=1 still builds.
   localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [6:0]        IDX_LAST  = 7'(PKT_LEN - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
`ifdef PKT_TX_CHECKSUM_EN
   localparam logic [2:0] S_CSUM  = 3'd5;
`endif

   logic [2:0]        r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic [6:0]        r_idx;
   logic              r_tx;

   logic w_bit_end;
   logic w_last_byte;
   logic w_frame_end;
   logic w_pkt_end;
   logic w_tx_next;

`ifdef PKT_TX_CHECKSUM_EN
   logic [7:0] r_csum;        // running XOR of the payload bytes latched so far
   logic       r_csum_phase;  // set while the checksum frame is on the line
   assign w_pkt_end = r_csum_phase;
`else
   assign w_pkt_end = w_last_byte;
`endif

   assign w_bit_end   = (r_baud == BAUD_LAST);
   assign w_last_byte = (r_idx == IDX_LAST);
   assign w_frame_end = (r_state == S_STOP) && w_bit_end;

   assign idx       = r_idx;
   assign tx        = r_tx;
   assign busy      = (r_state != S_IDLE);
   assign byte_sent = w_frame_end;
   assign done      = w_frame_end && w_pkt_end;

   // Line level that goes with the current state. It is registered into r_tx
   // on the next edge, so the line lags the state by exactly one cycle.
   always_comb begin
      // NOTE: assign a default first, so no path through this block leaves
      // w_tx_next unassigned and infers a latch.
      w_tx_next = 1'b1;
      case (r_state)
         S_START: w_tx_next = 1'b0;
         S_DATA:  w_tx_next = r_shift[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples values from before the edge, whatever the statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         r_tx    <= 1'b1;
`ifdef PKT_TX_CHECKSUM_EN
         r_csum       <= '0;
         r_csum_phase <= 1'b0;
`endif
      end else begin
         r_tx <= w_tx_next;
         case (r_state)
            S_IDLE: begin
               r_idx  <= '0;
               r_baud <= '0;
               r_bit  <= '0;
`ifdef PKT_TX_CHECKSUM_EN
               r_csum       <= '0;
               r_csum_phase <= 1'b0;
`endif
               if (start) r_state <= S_FETCH;
            end

            S_FETCH: begin
               r_shift <= read_data;
`ifdef PKT_TX_CHECKSUM_EN
               r_csum  <= r_csum ^ read_data;
`endif
               r_baud  <= '0;
               r_state <= S_START;
            end

            S_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (w_pkt_end) begin
                     r_idx   <= '0;
                     r_state <= S_IDLE;
                  end
`ifdef PKT_TX_CHECKSUM_EN
                  // idx stays at the last payload index during the checksum frame.
                  else if (w_last_byte) begin
                     r_state <= S_CSUM;
                  end
`endif
                  else begin
                     r_idx   <= r_idx + 7'd1;
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end

`ifdef PKT_TX_CHECKSUM_EN
            // Latch cycle for the checksum byte, which takes the place of FETCH.
            S_CSUM: begin
               r_shift      <= r_csum;
               r_csum_phase <= 1'b1;
               r_baud       <= '0;
               r_state      <= S_START;
            end
`endif

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_pkt_tx -- scoreboard bench for pkt_tx.
// The stimulus pushes the expected frame bytes into exp_q and then drives
// start. A UART monitor decodes the tx line on falling clock edges, pops each
// expected byte, and compares it. A second instance with PKT_LEN=1 and
// CLKS_PER_BIT=1 covers the shortest packet.
// -----------------------------------------------------------------------------
module tb_pkt_tx;

   localparam int CPB = 4;
   localparam int LEN = 3;
`ifdef PKT_TX_CHECKSUM_EN
   localparam int CSUM_EN = 1;
`else
   localparam int CSUM_EN = 0;
`endif
   localparam int NFRAMES   = LEN + CSUM_EN;
   localparam int FRAME_CYC = 1 + 10 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [6:0] idx;
   logic [7:0] read_data;
   logic       tx, busy, byte_sent, done;

   logic       start1;
   logic [6:0] idx1;
   logic       tx1, busy1, byte_sent1, done1;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   int         done_cnt  = 0;
   int         bs_cnt    = 0;
   int         busy1_cnt = 0;

   always #5 clk = ~clk;

   // Payload source: combinational from idx.
   always_comb begin
      read_data = 8'h00;
      case (idx)
         7'd0:    read_data = 8'h55;
         7'd1:    read_data = 8'hA0;
         7'd2:    read_data = 8'h0F;
         default: read_data = 8'h00;
      endcase
   end

   pkt_tx #(.CLKS_PER_BIT(CPB), .PKT_LEN(LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .idx       (idx),
      .read_data (read_data),
      .tx        (tx),
      .busy      (busy),
      .byte_sent (byte_sent),
      .done      (done)
   );

   pkt_tx #(.CLKS_PER_BIT(1), .PKT_LEN(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .start     (start1),
      .idx       (idx1),
      .read_data (8'h55),
      .tx        (tx1),
      .busy      (busy1),
      .byte_sent (byte_sent1),
      .done      (done1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   // Expected frames of one packet: 0x55, 0xA0, 0x0F, then 0xFA if the checksum is enabled.
   task automatic push_packet();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'h0F);
      if (CSUM_EN != 0) exp_q.push_back(8'hFA);
   endtask

   // Counts further busy cycles, sampled 1 time unit after each rising edge.
   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (busy && n < 2000) begin
         @(posedge clk); #1;
         if (busy) n++;
      end
      if (busy) fail_timeout(tag);
   endtask

   task automatic wait_idx(input string tag, input logic [6:0] v);
      int k;
      k = 0;
      while (idx !== v && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      if (idx !== v) fail_timeout(tag);
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (done !== 1'b1 && k < 2000);
      if (done !== 1'b1) fail_timeout(tag);
   endtask

   // UART monitor: m_cnt is the position within the frame (-1 while idle).
   int         m_cnt = -1;
   int         slot, off;
   logic [7:0] m_byte;
   logic       m_err;
   logic [7:0] exp_b;

   always @(negedge clk) begin
      if (reset) begin
         m_cnt = -1;
      end else if (m_cnt < 0) begin
         if (tx === 1'b0) begin
            m_cnt  = 1;
            m_err  = 1'b0;
            m_byte = 8'h00;
         end
      end else begin
         slot = m_cnt / CPB;
         off  = m_cnt % CPB;
         if (slot == 0) begin
            if (tx !== 1'b0) m_err = 1'b1;
         end else if (slot <= 8) begin
            if (off == 0) m_byte[3'(slot - 1)] = tx;
            else if (tx !== m_byte[3'(slot - 1)]) m_err = 1'b1;
         end else if (tx !== 1'b1) begin
            m_err = 1'b1;
         end
         // The line lags the state by one cycle, so byte_sent appears on the
         // second-to-last cycle of the stop bit as seen on tx.
         if (m_cnt == 10 * CPB - 2) check("byte_sent_align", 32'(byte_sent), 32'd1);
         if (m_cnt == 10 * CPB - 1) begin
            check("frame_shape", 32'(m_err), 32'd0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_frame: got 0x%0h, no frame expected", m_byte);
            end else begin
               exp_b = exp_q.pop_front();
               check("frame_byte", 32'(m_byte), 32'(exp_b));
            end
            m_cnt = -1;
         end else begin
            m_cnt++;
         end
      end
   end

   // Pulse counters, plus the check that done falls on the final stop cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            done_cnt++;
            check("done_in_last_stop", 32'({busy, byte_sent, idx}), 32'({1'b1, 1'b1, 7'(LEN - 1)}));
         end
         if (byte_sent) bs_cnt++;
         if (busy1) busy1_cnt++;
         if (done1) check("done1_with_byte_sent", 32'(byte_sent1), 32'd1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, b0, n;
      logic [9:0] frame;
      logic [1:0] flags;

      start  = 1'b0;
      start1 = 1'b0;
      reset  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'({tx, busy, idx, byte_sent, done}), 32'({1'b1, 1'b0, 7'd0, 1'b0, 1'b0}));
      check("reset_state_1", 32'({tx1, busy1, idx1}), 32'({1'b1, 1'b0, 7'd0}));
      @(negedge clk);
      reset = 1'b0;

      // ---- A: single packet, latency and busy length ----
      push_packet();
      d0 = done_cnt; b0 = bs_cnt;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("lat_e0", 32'({busy, idx, tx}), 32'({1'b1, 7'd0, 1'b1}));
      @(posedge clk); #1;
      check("lat_e1", 32'(tx), 32'd1);
      @(posedge clk); #1;
      check("lat_e2", 32'(tx), 32'd0);
      wait_idle("pktA", n);
      check("busy_len_A", 32'(3 + n), 32'(NFRAMES * FRAME_CYC));
      repeat (3) @(negedge clk);
      check("drain_A", 32'(exp_q.size()), 32'd0);
      check("done_cnt_A", 32'(done_cnt - d0), 32'd1);
      check("bs_cnt_A", 32'(bs_cnt - b0), 32'(NFRAMES));

      // ---- B: start while busy is ignored ----
      push_packet();
      d0 = done_cnt; b0 = bs_cnt;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_idx("wait_idx1_B", 7'd1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_idle("pktB", n);
      repeat (3) @(negedge clk);
      check("drain_B", 32'(exp_q.size()), 32'd0);
      check("done_cnt_B", 32'(done_cnt - d0), 32'd1);
      check("bs_cnt_B", 32'(bs_cnt - b0), 32'(NFRAMES));
      repeat (10) @(negedge clk);
      check("start_not_queued", 32'(busy), 32'd0);

      // ---- D: start held high gives back-to-back packets ----
      push_packet();
      push_packet();
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      wait_done("done_D1");
      check("idx_before_wrap", 32'(idx), 32'(LEN - 1));
      @(posedge clk); #1;
      check("b2b_idle_gap", 32'({busy, idx}), 32'({1'b0, 7'd0}));
      @(posedge clk); #1;
      check("b2b_restart", 32'({busy, idx}), 32'({1'b1, 7'd0}));
      start = 1'b0;
      wait_idle("pktD2", n);
      check("busy_len_D2", 32'(1 + n), 32'(NFRAMES * FRAME_CYC));
      repeat (3) @(negedge clk);
      check("drain_D", 32'(exp_q.size()), 32'd0);
      check("done_cnt_D", 32'(done_cnt - d0), 32'd2);

      // ---- C: reset during DATA bit 3 of byte 1 ----
      push_packet();
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_idx("wait_idx1_C", 7'd1);
      // FETCH (1) + START (4) + data bits 0..2 (12) puts bit 3 17 cycles on.
      repeat (18) @(posedge clk);
      #2;
      check("pre_reset_busy", 32'({busy, idx}), 32'({1'b1, 7'd1}));
      reset = 1'b1;
      #1;
      check("async_reset", 32'({tx, busy, idx, byte_sent, done}), 32'({1'b1, 1'b0, 7'd0, 1'b0, 1'b0}));
      exp_q.delete();
      @(negedge clk);
      @(posedge clk); #2;
      reset = 1'b0;
      check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
      push_packet();
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("restart_idx0", 32'({busy, idx}), 32'({1'b1, 7'd0}));
      wait_idle("pktC", n);
      repeat (3) @(negedge clk);
      check("drain_C", 32'(exp_q.size()), 32'd0);
      check("done_cnt_C", 32'(done_cnt - d0), 32'd1);

      // ---- E: PKT_LEN=1, CLKS_PER_BIT=1 ----
      busy1_cnt = 0;
      flags = 2'b00;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         frame[i] = tx1;
         if (i == 8) flags = {byte_sent1, done1};
      end
      check("short_frame", 32'(frame), 32'({1'b1, 8'h55, 1'b0}));
      check("short_flags", 32'(flags), 32'({1'b1, (CSUM_EN == 0)}));
      check("short_idx", 32'(idx1), 32'd0);
      repeat (30) @(negedge clk);
      check("short_busy_len", 32'(busy1_cnt), 32'(11 * (1 + CSUM_EN)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pkt_tx.md
PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter PKT_LEN, default 60: payload bytes per packet, range 1-127.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  packet request; sampled only in IDLE.
REQ-006 SHALL have port idx  output  7  index of the payload byte being fetched, 0..PKT_LEN-1.
REQ-007 SHALL have port read_data  input  8  payload byte addressed by idx; combinational from idx at the source.
REQ-008 SHALL have port tx  output  1  UART line, 8N1, LSB first, idle high, driven from a flop.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port byte_sent  output  1  one-cycle pulse at the end of each stop bit.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the packet completes.

Function
REQ-012 SHALL implement states IDLE, FETCH, START, DATA, STOP, plus CSUM when checksum is enabled.
REQ-013 IDLE: tx=1, idx=0; start=1 -> FETCH on the same edge; start=0 -> stay in IDLE.
REQ-014 FETCH: lasts exactly 1 cycle; latch read_data into an 8-bit shift register; -> START.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles; -> DATA.
REQ-016 DATA: shift out 8 bits LSB first, each held for CLKS_PER_BIT cycles; a 3-bit bit counter; -> STOP after bit 7.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; on the last cycle pulse byte_sent.
REQ-018 STOP exit when idx<PKT_LEN-1: increment idx -> FETCH.
REQ-019 STOP exit when idx=PKT_LEN-1: -> CSUM if enabled, otherwise -> IDLE with done pulsed the same cycle.
REQ-020 Latency: tx SHALL first fall 2 clk edges after the edge that samples start.
REQ-021 Per-byte period SHALL be exactly 1+10*CLKS_PER_BIT cycles; no idle gap between bytes beyond the FETCH cycle.
REQ-022 start while busy SHALL be ignored, not queued.
REQ-023 start held high across completion SHALL begin a new packet on the edge after returning to IDLE.
REQ-024 idx SHALL stay stable from entry to FETCH through STOP, and SHALL never exceed PKT_LEN-1.
REQ-025 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, count 0..CLKS_PER_BIT-1, and wrap to 0 on every bit boundary.

Reset
REQ-026 reset asserted SHALL immediately force: IDLE, tx=1, idx=0, busy=0, byte_sent=0, done=0, counters and shift register 0, checksum 0.
REQ-027 reset mid-frame SHALL abort the frame with tx high at once; no done pulse; the next start SHALL begin at idx 0.

Configuration
REQ-028 Macro PKT_TX_CHECKSUM_EN defined: keep a running XOR of every latched payload byte; after the last payload STOP, enter CSUM and send the XOR byte as a frame (1 latch cycle + start/data/stop, byte_sent pulsed); then -> IDLE with done pulsed.
REQ-029 Macro PKT_TX_CHECKSUM_EN undefined: no CSUM state and no checksum logic; packet is exactly PKT_LEN frames.

Verification (CLKS_PER_BIT=4, PKT_LEN=3, source bytes 0x55,0xA0,0x0F)
REQ-030 Single packet: 1-cycle start -> tx low at edge+2; frames 0x55,0xA0,0x0F LSB first, each 41 cycles; 3 byte_sent pulses; done on the final STOP cycle; busy high for 123 cycles.
REQ-031 Checksum enabled -> 4th frame 0xFA (0x55^0xA0^0x0F); done after 4th byte_sent; busy high for 164 cycles.
REQ-032 start pulsed during byte 1 -> ignored; exactly 3 frames; done pulses once.
REQ-033 reset during DATA bit 3 of byte 1 -> tx=1, busy=0, idx=0 asynchronously; the next start resends from 0x55.
REQ-034 start held high continuously -> back-to-back packets separated by exactly 1 IDLE cycle; idx wraps 2->0.
REQ-035 PKT_LEN=1, CLKS_PER_BIT=1 -> a 0x55 frame of 11 cycles, with byte_sent and done coincident.
